// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared element type and packer FSM states for the dot-product path
package vector_pkg;

   localparam int ELEM_W = 8;

   typedef logic signed [ELEM_W-1:0] elem_t;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/vector_packer.sv
// rtl/vector_packer.sv - serial-to-parallel element packer with one-deep output buffering
module vector_packer
   import vector_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N*W-1:0]           out_vec,
   output logic [$clog2(N+1)-1:0]   out_count
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(N+1);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [N*W-1:0]  fill_q, fill_d;
   logic [N*W-1:0]  out_vec_q, out_vec_d;
   logic [CW-1:0]   out_count_q, out_count_d;
   logic            out_valid_q, out_valid_d;

   logic            accept;
   logic            closing;
   logic            slot_free;
   logic [N*W-1:0]  fill_beat;

   assign in_ready  = !reset && (state_q == FILL);
   assign accept    = in_valid && in_ready;
   assign closing   = accept && ((idx_q == IW'(N-1)) || in_last);
   assign slot_free = !out_valid_q || out_ready;

   // Fill buffer with the current beat written into its lane; untouched upper lanes stay zero.
   always_comb begin
      fill_beat = fill_q;
      fill_beat[idx_q*W +: W] = in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FILL;
         idx_q       <= '0;
         fill_q      <= '0;
         out_vec_q   <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         fill_q      <= fill_d;
         out_vec_q   <= out_vec_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (closing && !slot_free) state_d = HOLD;
         HOLD:    if (out_ready) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      fill_d      = fill_q;
      idx_d       = idx_q;
      out_vec_d   = out_vec_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q && !out_ready;
      case (state_q)
         FILL: begin
            if (closing && slot_free) begin
               out_vec_d   = fill_beat;
               out_count_d = CW'(idx_q) + CW'(1);
               out_valid_d = 1'b1;
               fill_d      = '0;
               idx_d       = '0;
            end else if (closing) begin
               // idx stays on the closing lane so HOLD can derive the count
               fill_d = fill_beat;
            end else if (accept) begin
               fill_d = fill_beat;
               idx_d  = idx_q + IW'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_vec_d   = fill_q;
               out_count_d = CW'(idx_q) + CW'(1);
               out_valid_d = 1'b1;
               fill_d      = '0;
               idx_d       = '0;
            end
         end
         default: ;
      endcase
   end

   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_vector_packer.sv
// tb/tb_vector_packer.sv - randomized scoreboard bench for vector_packer
module tb_vector_packer;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = $clog2(N+1);

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [N*W-1:0]  out_vec;
   logic [CW-1:0]   out_count;

   typedef struct {
      logic [N*W-1:0] vec;
      int             count;
   } exp_t;

   exp_t        exp_q[$];
   logic [W-1:0] part[$];
   int          checks = 0;
   int          errors = 0;
   bit          just_reset = 1'b0;
   bit          rand_ready = 1'b0;

   vector_packer #(.N(N), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: accepted beats gather in a list; a full or in_last-closed list becomes a vector.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            check("in_ready_during_reset", in_ready, 0);
            exp_q.delete();
            part.delete();
            just_reset = 1'b1;
         end else begin
            if (just_reset) begin
               check("reset_out_vec", out_vec, 0);
               check("reset_out_count", out_count, 0);
               just_reset = 1'b0;
            end
            check("in_ready", in_ready, (exp_q.size() < 2) ? 1 : 0);
            check("out_valid", out_valid, (exp_q.size() > 0) ? 1 : 0);
            if (out_valid && exp_q.size() > 0) begin
               check("out_vec", out_vec, exp_q[0].vec);
               check("out_count", out_count, exp_q[0].count);
               if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
               part.push_back(in_data);
               if (part.size() == N || in_last) begin
                  exp_t e;
                  e.vec   = '0;
                  e.count = part.size();
                  for (int i = 0; i < part.size(); i++) e.vec[i*W +: W] = part[i];
                  exp_q.push_back(e);
                  part.delete();
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic beat(input int d, input bit l);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      in_valid = 1'b1;
      in_data  = d[W-1:0];
      in_last  = l;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check("beat_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_last = 1'($urandom_range(0, 1));
         in_data = W'($urandom_range(0, 255));
         @(posedge clk);
         #1;
      end
      in_last = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [N*W-1:0] ones;
      logic [N*W-1:0] twos;
      ones = '0;
      twos = '0;
      for (int i = 0; i < N; i++) begin
         ones[i*W +: W] = W'(1);
         twos[i*W +: W] = W'(2);
      end
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      for (int v = 1; v <= 4; v++) beat(v, 1'b0);
      idle(3);
      beat(5, 1'b0);
      beat(-6, 1'b1);
      beat(9, 1'b1);
      idle(3);

      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) beat(1, 1'b0);
      for (int i = 0; i < 4; i++) beat(2, 1'b0);
      idle(3);
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_first_vec", out_vec, ones);
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk);
      check("release_vec", out_vec, twos);
      check("release_in_ready", in_ready, 1);
      @(posedge clk); #1; out_ready = 1'b1;
      idle(3);

      for (int i = 0; i < 5*N; i++) beat(int'($urandom_range(0, 255)) - 128, 1'b0);
      idle(3);

      beat(3, 1'b0);
      beat(4, 1'b0);
      do_reset();
      for (int i = 0; i < N; i++) beat(10 + i, 1'b0);
      idle(3);

      out_ready = 1'b0;
      for (int i = 0; i < 2*N; i++) beat(20 + i, 1'b0);
      idle(2);
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) beat(30 + i, 1'b0);
      idle(3);

      beat(7, 1'b1);
      idle(3);

      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else beat(int'($urandom_range(0, 255)) - 128, $urandom_range(0, 4) == 0);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      idle(10);
      check("drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_packer.md
# vector_packer

Serial-to-parallel front end of the dot-product path. Collects signed elements arriving one per beat on a valid/ready stream and assembles them into an N-element vector. Presents each completed vector, with its element count, on a valid/ready output that feeds the vector accumulator. Output buffering lets the next vector fill while the current one waits for the consumer.

## Interface
- N, 4, elements per vector (≥2)
- W, 8, element width in bits (signed)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  element beat offered
- in_ready  out  1  packer can accept a beat
- in_data  in  W  signed element
- in_last  in  1  beat closes the vector early (short vector)
- out_valid  out  1  vector held on out_vec
- out_ready  in  1  consumer takes the vector
- out_vec  out  N×W  signed elements; lane 0 = first beat received
- out_count  out  $clog2(N+1)  valid lanes, 1..N

## Operation
- Beat accepted when in_valid && in_ready; in_data written to fill-buffer lane idx, idx increments.
- Closing beat: accepted beat with idx==N-1 or in_last=1. Lanes above the closing lane are zero in the completed vector. count = idx+1.
- Output slot free when !out_valid || out_ready.
- FSM states:
  - FILL: in_ready=1. On a closing beat with slot free, the completed vector (including this beat) loads into out_vec/out_count, out_valid=1, fill buffer cleared, idx=0, stay FILL. On a closing beat with slot busy, go to HOLD; fill buffer keeps the vector.
  - HOLD: in_ready=0. When out_ready=1, out_vec/out_count load from the fill buffer, out_valid stays 1, fill cleared, idx=0, go to FILL.
- out_valid falls only when out_ready=1 and no new vector loads in the same cycle.
- out_vec/out_count stable while out_valid && !out_ready.
- in_last ignored on cycles where no beat is accepted.
- in_last on lane N-1 is an ordinary closing beat: count=N.
- Reset mid-vector discards partial fill and any held output.

## Timing
- Reset values: out_valid=0, out_vec=0, out_count=0, state=FILL, idx=0, fill buffer=0.
- in_ready=0 during any cycle with reset=1; it is 1 on the first cycle after reset.
- in_ready is combinational from state only, with no path from out_ready.
- Latency: out_valid rises the cycle after the closing beat is accepted, if the slot is free.
- Throughput: one full vector per N cycles with no bubble when out_ready is held high.
- Stall: if the closing beat finds the slot busy, in_ready drops the next cycle. It recovers the cycle after out_ready is sampled high in HOLD.
- A simultaneous closing beat and out_ready both transfer in that cycle, and out_valid stays 1.

## Structure
- Shared package vector_pkg:
  - ELEM_W default (8)
  - typedef elem_t = logic signed [ELEM_W-1:0]
  - typedef state enum {FILL, HOLD}
  - the accumulator imports the same elem_t
- Flat module: fill buffer, idx counter, output register, 2-state FSM. No sub-module is warranted.

## Test plan
- Reset then beats 1,2,3,4 back-to-back, out_ready=1:
  - in_ready=1 throughout
  - out_valid rises the cycle after beat 4
  - out_vec={1,2,3,4}, out_count=4
- Beats 5,-6 with in_last on -6:
  - out_vec={5,-6,0,0}, out_count=2
  - next vector starts at lane 0
- out_ready=0, stream vectors {1,1,1,1} then {2,2,2,2}:
  - first vector held stable
  - in_ready drops after the 8th beat (HOLD)
  - out_ready=1 for one cycle → out_vec={2,2,2,2} the next cycle, in_ready=1
- Continuous in_valid with out_ready=1 for 5 vectors of -128..127 values:
  - 5 outputs, one every 4 cycles, exact lane order
  - no in_ready deassertion
- Reset asserted after 2 beats of a vector, and again with a vector held in HOLD:
  - out_valid=0, out_count=0, out_vec=0 the next cycle
  - following beats start at lane 0
- in_last on the first beat (value 7):
  - out_vec={7,0,0,0}, out_count=1
- in_valid toggling randomly with random in_last:
  - no beat lost or duplicated versus a reference queue
